push_conditioner: RTL and testbench
===================================

PUSH_CONDITIONER -- requirements
Module: push_conditioner

Interface
REQ-001 Parameter SAMPLE_DIV, default 22'd2000: sample-tick divider; one tick every SAMPLE_DIV+1 CLK cycles.
REQ-002 Parameter DEBOUNCE_N, default 4: consecutive equal ticks needed to accept a level change; legal range 2..15.
REQ-003 Parameter REPEAT_DELAY, default 150: ticks from accepted press to first auto-repeat pulse; legal range 1..255.
REQ-004 Parameter REPEAT_RATE, default 40: ticks between later auto-repeat pulses; legal range 1..255.
REQ-005 CLK  input  1  single system clock, rising edge.
REQ-006 RSTn  input  1  reset, asynchronous, active-low.
REQ-007 PUSH  input  4  raw push buttons, asynchronous, 1 = pressed.
REQ-008 PRESS  output  4  one-CLK press pulse per button, consumed by the bar-movement logic.
REQ-009 LEVEL  output  4  debounced button level.
REQ-010 TICK  output  1  one-CLK sample-tick strobe, exported for debug.

Function
REQ-011 Prescaler SHALL count 0..SAMPLE_DIV, wrap to 0, and assert TICK only in the cycle where count == SAMPLE_DIV.
REQ-012 Each PUSH bit SHALL pass through a 2-flop synchronizer clocked every CLK; only the second flop output (S) is used.
REQ-013 Per button, on TICK: if S == LEVEL then the debounce counter SHALL clear; otherwise it SHALL increment.
REQ-014 When the increment brings the count to DEBOUNCE_N, LEVEL SHALL toggle in that cycle and the counter SHALL clear.
REQ-015 Debounce counters SHALL hold their value in non-TICK cycles.
REQ-016 PRESS[i] SHALL be high for exactly one CLK cycle, in the cycle LEVEL[i] first reads 1 (a registered 0->1 edge).
REQ-017 A LEVEL 1->0 transition SHALL produce no pulse.
REQ-018 Latency from PUSH edge to LEVEL/PRESS SHALL be at most 2 + DEBOUNCE_N*(SAMPLE_DIV+1) + 1 cycles.
REQ-019 Buttons SHALL be fully independent: any combination of PRESS bits may be asserted in the same cycle.
REQ-020 A bounce whose period is shorter than DEBOUNCE_N ticks SHALL leave LEVEL unchanged and SHALL produce no PRESS.
REQ-021 When PUSH[3:2] both press, or PUSH[1:0] both press, both PRESS bits SHALL still pulse; left/right priority is left to the consumer.

Reset
REQ-022 RSTn low SHALL immediately clear the prescaler, synchronizers, debounce counters, repeat counters and states; PRESS, LEVEL and TICK SHALL read 0.
REQ-023 If a button is held across reset release, exactly one PRESS SHALL occur after normal debounce latency.
REQ-024 Assertion of RSTn mid-debounce or mid-repeat SHALL abort the sequence with no PRESS emitted.

Configuration
REQ-025 Macro PUSH_AUTOREPEAT_EN: when defined, each button SHALL have a 3-state FSM: IDLE, HELD, REPEAT.
REQ-026 FSM transitions:
- IDLE -> HELD on press acceptance (REQ-016 pulse); the repeat counter loads 0.
- HELD -> REPEAT on the TICK where the repeat counter reaches REPEAT_DELAY; PRESS pulses in that cycle.
- REPEAT: PRESS pulses on every REPEAT_RATE-th TICK.
- Any state -> IDLE in the cycle LEVEL falls, with no pulse.
REQ-027 Repeat counters SHALL be 8 bits, SHALL count only on TICK, and SHALL reload to 0 at each repeat pulse.
REQ-028 When PUSH_AUTOREPEAT_EN is undefined, no FSM or repeat counters SHALL exist, and PRESS SHALL pulse once per accepted press only.

Verification
REQ-029 The bench SHALL use SAMPLE_DIV=3, DEBOUNCE_N=4, REPEAT_DELAY=5 and REPEAT_RATE=2.
REQ-030 Press: PUSH=4'b0010 held 100 cycles (macro off) -> exactly one PRESS[1] pulse, 1 cycle wide, within 19 cycles; LEVEL[1]=1; TICK period 4 cycles.
REQ-031 Bounce: PUSH[0] toggles every 5 cycles for 40 cycles then stays 0 -> PRESS=0 and LEVEL=0 throughout.
REQ-032 Auto-repeat: macro on, PUSH[2] held 200 cycles -> first PRESS[2]; second PRESS[2] 20 cycles later; then a PRESS[2] every 8 cycles; none after release.
REQ-033 Simultaneous: PUSH 0000 -> 1001 in one cycle -> PRESS[0] and PRESS[3] high in the same cycle; PRESS[2:1]=0.
REQ-034 Reset mid-hold: RSTn low for 3 cycles while LEVEL[3]=1 -> LEVEL, PRESS and TICK are 0 before the next CLK edge.
REQ-035 Reset release with PUSH[3] still held -> one new PRESS[3] within 19 cycles.
REQ-036 Release: PUSH[1] 1 -> 0 -> LEVEL[1] falls within 19 cycles with no PRESS pulse.

Source files
------------

// File: rtl/push_conditioner.sv
// Four-button input conditioner: 2-flop synchronizer, tick-sampled debouncer and
// one-cycle press pulses. Define PUSH_AUTOREPEAT_EN to add a per-button auto-repeat FSM.
module push_conditioner #(
  parameter logic [21:0] SAMPLE_DIV   = 22'd2000,
  parameter int          DEBOUNCE_N   = 4,
  parameter int          REPEAT_DELAY = 150,
  parameter int          REPEAT_RATE  = 40
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] PUSH,
  output logic [3:0] PRESS,
  output logic [3:0] LEVEL,
  output logic       TICK
);

  logic [21:0] div_cnt;
  logic [3:0]  sync_a;
  logic [3:0]  sync_b;
  logic [3:0]  db_cnt [4];
  logic [3:0]  accept;

  assign TICK = (div_cnt == SAMPLE_DIV);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)     div_cnt <= '0;
    else if (TICK) div_cnt <= '0;
    else           div_cnt <= div_cnt + 22'd1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= PUSH;
      sync_b <= sync_a;
    end
  end

  // accept[i]: this tick completes a run of DEBOUNCE_N samples disagreeing with LEVEL
  always_comb begin
    accept = '0;
    for (int i = 0; i < 4; i++)
      accept[i] = TICK && (sync_b[i] != LEVEL[i]) && (db_cnt[i] == 4'(DEBOUNCE_N - 1));
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      LEVEL <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (TICK) begin
          if ((sync_b[i] == LEVEL[i]) || accept[i]) db_cnt[i] <= '0;
          else                                      db_cnt[i] <= db_cnt[i] + 4'd1;
        end
      end
      LEVEL <= LEVEL ^ accept;
    end
  end

`ifdef PUSH_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} rep_state_t;

  rep_state_t state   [4];
  logic [7:0] rep_cnt [4];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      PRESS <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i]   <= IDLE;
        rep_cnt[i] <= '0;
      end
    end else begin
      PRESS <= '0;
      for (int i = 0; i < 4; i++) begin
        if (accept[i] && LEVEL[i]) begin
          state[i]   <= IDLE;
          rep_cnt[i] <= '0;
        end else if (accept[i]) begin
          state[i]   <= HELD;
          rep_cnt[i] <= '0;
          PRESS[i]   <= 1'b1;
        end else if (TICK) begin
          case (state[i])
            HELD: begin
              if (rep_cnt[i] == 8'(REPEAT_DELAY - 1)) begin
                state[i]   <= REPEAT;
                rep_cnt[i] <= '0;
                PRESS[i]   <= 1'b1;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + 8'd1;
              end
            end
            REPEAT: begin
              if (rep_cnt[i] == 8'(REPEAT_RATE - 1)) begin
                rep_cnt[i] <= '0;
                PRESS[i]   <= 1'b1;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + 8'd1;
              end
            end
            default: rep_cnt[i] <= '0;
          endcase
        end
      end
    end
  end
`else
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) PRESS <= '0;
    else       PRESS <= accept & ~LEVEL;
  end
`endif

endmodule

// File: tb/tb_push_conditioner.sv
// Bench for push_conditioner: randomized and directed stimulus against a tick-level
// reference model; covers the optional PUSH_AUTOREPEAT_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_push_conditioner;
  localparam logic [21:0] SAMPLE_DIV = 22'd3;
  localparam int DEBOUNCE_N   = 4;
  localparam int REPEAT_DELAY = 5;
  localparam int REPEAT_RATE  = 2;
  localparam int TP           = 4;
`ifdef PUSH_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       CLK  = 1'b0;
  logic       RSTn = 1'b0;
  logic [3:0] PUSH = 4'b0;
  logic [3:0] PRESS;
  logic [3:0] LEVEL;
  logic       TICK;

  int n_cmp = 0;
  int n_err = 0;

  push_conditioner #(
    .SAMPLE_DIV(SAMPLE_DIV), .DEBOUNCE_N(DEBOUNCE_N),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .PUSH(PUSH), .PRESS(PRESS), .LEVEL(LEVEL), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  // Reference model: a button flips once the last DEBOUNCE_N tick samples all disagree
  // with its level; repeats fire REPEAT_DELAY ticks after a press, then every REPEAT_RATE.
  int unsigned edge_k = 0;
  logic [3:0]  p1 = 4'b0, p2 = 4'b0;
  logic [3:0]  m_level = 4'b0, m_press = 4'b0;
  logic        m_tick = 1'b0;
  bit          hist [4][$];
  int          since [4];
  bit          held [4];
  bit          all_diff;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      edge_k = 0; p1 = '0; p2 = '0; m_level = '0; m_press = '0;
      for (int i = 0; i < 4; i++) begin
        hist[i].delete(); since[i] = 0; held[i] = 1'b0;
      end
    end else begin
      edge_k++;
      m_press = '0;
      if (edge_k % TP == 0) begin
        for (int i = 0; i < 4; i++) begin
          hist[i].push_back(p2[i]);
          if (hist[i].size() > DEBOUNCE_N) void'(hist[i].pop_front());
          all_diff = (hist[i].size() == DEBOUNCE_N);
          for (int j = 0; j < hist[i].size(); j++)
            if (hist[i][j] == m_level[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_level[i] = ~m_level[i];
            if (m_level[i]) begin
              m_press[i] = 1'b1; held[i] = 1'b1; since[i] = 0;
            end else begin
              held[i] = 1'b0;
            end
          end else if (AR && held[i]) begin
            since[i]++;
            if (since[i] == REPEAT_DELAY ||
                (since[i] > REPEAT_DELAY && (since[i] - REPEAT_DELAY) % REPEAT_RATE == 0))
              m_press[i] = 1'b1;
          end
        end
      end
      p2 = p1;
      p1 = PUSH;
    end
    m_tick = (edge_k % TP == TP - 1);
  end

  task automatic test_reset();
    RSTn = 1'b0; PUSH = 4'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (PRESS !== 4'b0) begin n_err++; $display("FAIL reset_press got=%b exp=0000", PRESS); end
    n_cmp++; if (LEVEL !== 4'b0) begin n_err++; $display("FAIL reset_level got=%b exp=0000", LEVEL); end
    n_cmp++; if (TICK !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", TICK); end
    RSTn = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      n_cmp++;
      if ({PRESS, LEVEL, TICK} !== {m_press, m_level, m_tick}) begin
        n_err++; $display("FAIL reset_release c=%0d got=%b exp=%b", c, {PRESS, LEVEL, TICK}, {m_press, m_level, m_tick});
      end
    end
  endtask

  task automatic test_press();
    int pulses = 0, first = -1, last_tick = -1;
    bit tick_ok = 1'b1;
    PUSH = 4'b0010;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      n_cmp++;
      if ({PRESS, LEVEL, TICK} !== {m_press, m_level, m_tick}) begin
        n_err++; $display("FAIL press_model c=%0d got=%b exp=%b", c, {PRESS, LEVEL, TICK}, {m_press, m_level, m_tick});
      end
      if (PRESS[1]) begin
        if (first < 0) first = c;
        if (!AR || c - first < 20) pulses++;
      end
      if (TICK) begin
        if (last_tick >= 0 && c - last_tick != TP) tick_ok = 1'b0;
        last_tick = c;
      end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL press_count got=%0d exp=1", pulses); end
    n_cmp++; if (first < 1 || first > 19) begin n_err++; $display("FAIL press_latency got=%0d exp=1..19", first); end
    n_cmp++; if (LEVEL[1] !== 1'b1) begin n_err++; $display("FAIL press_level got=%b exp=1", LEVEL[1]); end
    n_cmp++; if (tick_ok !== 1'b1 || last_tick < 0) begin n_err++; $display("FAIL tick_period got_ok=%b exp_period=%0d", tick_ok, TP); end
  endtask

  task automatic test_release();
    int fall = -1, bad = 0;
    PUSH = 4'b0000;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      n_cmp++;
      if ({PRESS, LEVEL, TICK} !== {m_press, m_level, m_tick}) begin
        n_err++; $display("FAIL release_model c=%0d got=%b exp=%b", c, {PRESS, LEVEL, TICK}, {m_press, m_level, m_tick});
      end
      if (fall < 0 && LEVEL[1] === 1'b0) fall = c;
      if (PRESS[1] && (!AR || fall >= 0)) bad++;
    end
    n_cmp++; if (fall < 1 || fall > 19) begin n_err++; $display("FAIL release_latency got=%0d exp=1..19", fall); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL release_pulse got=%0d exp=0", bad); end
  endtask

  task automatic test_bounce();
    PUSH = 4'b0001;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      n_cmp++;
      if ({PRESS, LEVEL} !== 8'b0 || {PRESS, LEVEL, TICK} !== {m_press, m_level, m_tick}) begin
        n_err++; $display("FAIL bounce c=%0d got=%b exp=%b", c, {PRESS, LEVEL, TICK}, {8'b0, m_tick});
      end
      if (c < 40 && c % 5 == 0) PUSH[0] = ~PUSH[0];
      if (c == 40) PUSH = 4'b0000;
    end
  endtask

  task automatic test_hold();
    int pc [$];
    int bad_gap = 0, after = 0;
    bit fell = 1'b0;
    PUSH = 4'b0100;
    for (int c = 1; c <= 200; c++) begin
      @(negedge CLK);
      n_cmp++;
      if ({PRESS, LEVEL, TICK} !== {m_press, m_level, m_tick}) begin
        n_err++; $display("FAIL hold_model c=%0d got=%b exp=%b", c, {PRESS, LEVEL, TICK}, {m_press, m_level, m_tick});
      end
      if (PRESS[2]) pc.push_back(c);
    end
    if (AR) begin
      for (int j = 2; j < pc.size(); j++) if (pc[j] - pc[j-1] != 8) bad_gap++;
      n_cmp++; if (pc.size() < 4) begin n_err++; $display("FAIL repeat_count got=%0d exp>=4", pc.size()); end
      else begin
        n_cmp++; if (pc[1] - pc[0] != 20) begin n_err++; $display("FAIL repeat_first_gap got=%0d exp=20", pc[1] - pc[0]); end
        n_cmp++; if (bad_gap != 0) begin n_err++; $display("FAIL repeat_rate_gap got=%0d bad exp=0", bad_gap); end
      end
    end else begin
      n_cmp++; if (pc.size() != 1) begin n_err++; $display("FAIL hold_single got=%0d exp=1", pc.size()); end
    end
    PUSH = 4'b0000;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      n_cmp++;
      if ({PRESS, LEVEL, TICK} !== {m_press, m_level, m_tick}) begin
        n_err++; $display("FAIL hold_release c=%0d got=%b exp=%b", c, {PRESS, LEVEL, TICK}, {m_press, m_level, m_tick});
      end
      if (LEVEL[2] === 1'b0) fell = 1'b1;
      if (fell && PRESS[2]) after++;
    end
    n_cmp++; if (after != 0 || !fell) begin n_err++; $display("FAIL hold_after_release got=%0d fell=%b exp=0 fell=1", after, fell); end
  endtask

  task automatic test_simultaneous();
    int hit = -1;
    logic [3:0] seen = 4'b0;
    PUSH = 4'b1001;
    for (int c = 1; c <= 25; c++) begin
      @(negedge CLK);
      n_cmp++;
      if ({PRESS, LEVEL, TICK} !== {m_press, m_level, m_tick}) begin
        n_err++; $display("FAIL simul_model c=%0d got=%b exp=%b", c, {PRESS, LEVEL, TICK}, {m_press, m_level, m_tick});
      end
      if (hit < 0 && PRESS != 4'b0) begin hit = c; seen = PRESS; end
    end
    n_cmp++; if (seen !== 4'b1001) begin n_err++; $display("FAIL simul_press got=%b exp=1001 at c=%0d", seen, hit); end
    PUSH = 4'b0000;
    repeat (25) @(negedge CLK);
    n_cmp++; if (LEVEL !== 4'b0) begin n_err++; $display("FAIL simul_release got=%b exp=0000", LEVEL); end
  endtask

  task automatic test_reset_mid_hold();
    int reached = -1, pulses = 0, first = -1;
    PUSH = 4'b1000;
    for (int c = 1; c <= 25 && reached < 0; c++) begin
      @(negedge CLK);
      if (LEVEL[3] === 1'b1) reached = c;
    end
    n_cmp++; if (reached < 0) begin n_err++; $display("FAIL midhold_level got=0 exp=1"); end
    @(posedge CLK); #1;
    RSTn = 1'b0;
    #1;
    n_cmp++;
    if ({PRESS, LEVEL, TICK} !== 9'b0) begin
      n_err++; $display("FAIL midhold_async got=%b exp=000000000", {PRESS, LEVEL, TICK});
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      n_cmp++;
      if ({PRESS, LEVEL, TICK} !== 9'b0) begin
        n_err++; $display("FAIL midhold_in_reset c=%0d got=%b exp=000000000", c, {PRESS, LEVEL, TICK});
      end
    end
    RSTn = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      n_cmp++;
      if ({PRESS, LEVEL, TICK} !== {m_press, m_level, m_tick}) begin
        n_err++; $display("FAIL postreset_model c=%0d got=%b exp=%b", c, {PRESS, LEVEL, TICK}, {m_press, m_level, m_tick});
      end
      if (PRESS[3]) begin
        if (first < 0) first = c;
        if (c - first < 20) pulses++;
      end
    end
    n_cmp++; if (pulses != 1 || first > 19) begin n_err++; $display("FAIL postreset_press got=%0d at c=%0d exp=1 within 19", pulses, first); end
    PUSH = 4'b0000;
    repeat (25) @(negedge CLK);
  endtask

  task automatic test_random();
    int hold;
    for (int s = 0; s < 20; s++) begin
      PUSH = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 40);
      for (int c = 0; c < hold; c++) begin
        @(negedge CLK);
        n_cmp++;
        if ({PRESS, LEVEL, TICK} !== {m_press, m_level, m_tick}) begin
          n_err++; $display("FAIL random seg=%0d c=%0d push=%b got=%b exp=%b", s, c, PUSH, {PRESS, LEVEL, TICK}, {m_press, m_level, m_tick});
        end
      end
    end
    PUSH = 4'b0000;
    repeat (30) @(negedge CLK);
    n_cmp++; if (LEVEL !== m_level) begin n_err++; $display("FAIL random_settle got=%b exp=%b", LEVEL, m_level); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_hold();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
